// File: rtl/if_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_pkg
// Brief    : Shared constants and state encoding for the instruction fetch unit
// Revision : 1.0
// ============================================================================
package if_fetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] c_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/if_fetch_unit_adder.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit_adder
// Brief    : Parameterised N-bit ripple-carry adder; carry-out is dropped
// Revision : 1.0
// ============================================================================
module if_fetch_unit_adder #(
  parameter int N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic         i_cin,
  output logic [N-1:0] o_sum
);

  always_comb begin
    logic w_carry;
    w_carry = i_cin;
    o_sum   = '0;
    for (int i = 0; i < N; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_carry;
      w_carry  = (i_a[i] & i_b[i]) | (w_carry & (i_a[i] ^ i_b[i]));
    end
  end

endmodule
`default_nettype wire

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch_unit
// Brief    : IF stage: instruction memory request FSM, IF/ID register, skid
// Revision : 1.0
// ============================================================================
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic [XLEN-1:0] if_inst
);

  fetch_state_t    r_state;
  logic [XLEN-1:0] r_pc;
  logic            r_req;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_skid_inst;
  logic            r_valid;
  logic [XLEN-1:0] r_if_pc;
  logic [XLEN-1:0] r_if_pc4;
  logic [XLEN-1:0] r_if_inst;

  logic [XLEN-1:0] w_pc4;
  logic [XLEN-1:0] w_target;

  assign w_target = redirect_pc & ~32'h0000_0003;

  if_fetch_unit_adder #(
    .N (XLEN)
  ) u_pc4_adder (
    .i_a   (r_pc),
    .i_b   (32'h0000_0004),
    .i_cin (1'b0),
    .o_sum (w_pc4)
  );

  // The skid buffer only stores the instruction word: while in HOLD, r_pc
  // still holds the address of the parked instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_req       <= 1'b0;
      r_addr      <= RESET_PC;
      r_skid_inst <= '0;
      r_valid     <= 1'b0;
      r_if_pc     <= '0;
      r_if_pc4    <= '0;
      r_if_inst   <= c_NOP_INST;
    end else if (redirect) begin
      r_valid <= 1'b0;
      r_pc    <= w_target;
      r_req   <= 1'b1;
      if ((r_state == S_REQ || r_state == S_DRAIN) && !imem_ack) begin
        r_state <= S_DRAIN;
      end else begin
        r_state <= S_REQ;
        r_addr  <= w_target;
      end
    end else begin
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
          r_req   <= 1'b1;
          r_addr  <= r_pc;
        end
        S_REQ: begin
          if (imem_ack) begin
            if (stall && r_valid) begin
              r_skid_inst <= imem_rdata;
              r_req       <= 1'b0;
              r_state     <= S_HOLD;
            end else begin
              r_valid   <= 1'b1;
              r_if_pc   <= r_pc;
              r_if_pc4  <= w_pc4;
              r_if_inst <= imem_rdata;
              r_pc      <= w_pc4;
              r_addr    <= w_pc4;
            end
          end else if (!stall) begin
            r_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            r_valid   <= 1'b1;
            r_if_pc   <= r_pc;
            r_if_pc4  <= w_pc4;
            r_if_inst <= r_skid_inst;
            r_pc      <= w_pc4;
            r_addr    <= w_pc4;
            r_req     <= 1'b1;
            r_state   <= S_REQ;
          end
        end
        S_DRAIN: begin
          if (imem_ack) begin
            r_state <= S_REQ;
            r_addr  <= r_pc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_addr;
  assign if_valid  = r_valid;
  assign if_pc     = r_if_pc;
  assign if_pc4    = r_if_pc4;
  assign if_inst   = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch_unit
// Brief    : Self-checking bench for if_fetch_unit with an IF/ID scoreboard
// Revision : 1.0
// ============================================================================
module tb_if_fetch_unit;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [31:0] inst;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        stall, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ack;
  logic [31:0] imem_addr, imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc, if_pc4, if_inst;

  logic        req_w, ack_w, valid_w;
  logic [31:0] addr_w, rdata_w, pc_w, pc4_w, inst_w;

  exp_t        sb_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat = 1;
  int          mem_wait = 0;
  logic        force_ack = 1'b0;

  if_fetch_unit u_dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_pc4(if_pc4), .if_inst(if_inst)
  );

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_dut_wrap (
    .clk(clk), .rst(rst), .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .imem_req(req_w), .imem_addr(addr_w), .imem_ack(ack_w), .imem_rdata(rdata_w),
    .if_valid(valid_w), .if_pc(pc_w), .if_pc4(pc4_w), .if_inst(inst_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0013;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.pc4  = pc + 32'd4;
    e.inst = inst_of(pc);
    sb_q.push_back(e);
  endtask

  // One clock: memory responders decide ack, the monitor retires the IF/ID
  // entry the ID stage takes at this edge, then the edge is crossed.
  task automatic tick();
    exp_t e;
    ack_w   = req_w;
    rdata_w = inst_of(addr_w);
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hBAD0_0BAD;
    end else if (imem_req) begin
      mem_wait++;
      if (mem_wait >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = inst_of(imem_addr);
        mem_wait   = 0;
      end else begin
        imem_ack   = 1'b0;
      end
    end else begin
      imem_ack = 1'b0;
      mem_wait = 0;
    end
    if (if_valid && !stall && !redirect) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_if_valid", {31'd0, if_valid}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk("sb_if_pc", if_pc, e.pc);
        chk("sb_if_pc4", if_pc4, e.pc4);
        chk("sb_if_inst", if_inst, e.inst);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    imem_ack = 1'b0; imem_rdata = '0; ack_w = 1'b0; rdata_w = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_pc4", if_pc4, 32'd0);
    chk("rst_if_inst", if_inst, 32'h0000_0013);
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);

    // Release: request visible after the first edge, sampled at the second
    rst = 1'b0;
    tick();
    chk("first_req", {31'd0, imem_req}, 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    push(32'h0); push(32'h4); push(32'h8); push(32'hC);
    tick();
    chk("first_valid", {31'd0, if_valid}, 32'd1);
    chk("addr_4", imem_addr, 32'h4);
    chk("wrap_if_pc", pc_w, 32'hFFFF_FFFC);
    chk("wrap_if_pc4", pc4_w, 32'h0);
    chk("wrap_addr", addr_w, 32'h0);
    tick();
    chk("addr_8", imem_addr, 32'h8);

    // Ack on pc=8 while ID is stalled holding pc=4
    stall = 1'b1;
    tick();
    chk("hold_req", {31'd0, imem_req}, 32'd0);
    chk("hold_if_pc", if_pc, 32'h4);
    chk("hold_valid", {31'd0, if_valid}, 32'd1);
    tick();
    tick();
    chk("hold2_if_pc", if_pc, 32'h4);
    stall = 1'b0;
    tick();
    chk("unhold_if_pc", if_pc, 32'h8);
    chk("unhold_addr", imem_addr, 32'hC);
    tick();
    chk("addr_10", imem_addr, 32'h10);

    // Redirect while the 0x10 fetch is outstanding; ack lands 3 cycles later
    mem_lat = 5;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("flush_valid", {31'd0, if_valid}, 32'd0);
    chk("drain_addr0", imem_addr, 32'h10);
    chk("drain_req", {31'd0, imem_req}, 32'd1);
    tick();
    chk("drain_addr1", imem_addr, 32'h10);
    tick();
    chk("drain_addr2", imem_addr, 32'h10);
    tick();
    chk("post_drain_addr", imem_addr, 32'h100);
    chk("drain_discard", {31'd0, if_valid}, 32'd0);
    mem_lat = 1;
    tick();
    chk("tgt_valid", {31'd0, if_valid}, 32'd1);
    chk("tgt_if_pc", if_pc, 32'h100);
    chk("tgt_if_inst", if_inst, inst_of(32'h100));

    // Redirect and ack in the same cycle with stall: flush wins, no HOLD
    stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    chk("rs_valid", {31'd0, if_valid}, 32'd0);
    chk("rs_req", {31'd0, imem_req}, 32'd1);
    chk("rs_addr", imem_addr, 32'h200);
    // Stall over a bubble does not block the load
    push(32'h200);
    tick();
    chk("bubble_valid", {31'd0, if_valid}, 32'd1);
    chk("bubble_if_pc", if_pc, 32'h200);
    chk("bubble_addr", imem_addr, 32'h204);
    stall = 1'b0;
    tick();

    // Reset pulse while parked in HOLD
    stall = 1'b1;
    tick();
    chk("hold_b_req", {31'd0, imem_req}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk("arst_valid", {31'd0, if_valid}, 32'd0);
    chk("arst_if_pc", if_pc, 32'd0);
    chk("arst_if_pc4", if_pc4, 32'd0);
    chk("arst_if_inst", if_inst, 32'h0000_0013);
    chk("arst_req", {31'd0, imem_req}, 32'd0);
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst   = 1'b0;
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    chk("late_ack_valid", {31'd0, if_valid}, 32'd0);
    chk("restart_req", {31'd0, imem_req}, 32'd1);
    chk("restart_addr", imem_addr, 32'd0);
    push(32'h0);
    tick();
    tick();
    chk("sb_left", sb_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 Port: clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: stall  input  1  ID stage cannot accept; the IF/ID outputs shall hold while stall=1 and if_valid=1.
REQ-005 Port: redirect  input  1  taken branch/jump from EX.
REQ-006 Port: redirect_pc  input  32  target; bits [1:0] shall be forced to 0 on capture.
REQ-007 Port: imem_req  output  1  fetch request; held until imem_ack.
REQ-008 Port: imem_addr  output  32  fetch address; stable while imem_req=1 and no ack.
REQ-009 Port: imem_ack  input  1  imem_rdata valid this cycle; latency of 1..N cycles after request.
REQ-010 Port: imem_rdata  input  32  fetched instruction.
REQ-011 Port: if_valid, if_pc[31:0], if_pc4[31:0], if_inst[31:0]  output  IF/ID register contents.

Function
REQ-012 States shall be IDLE, REQ, HOLD and DRAIN.
- IDLE: reset state; go to REQ unconditionally next cycle.
REQ-013 imem_req shall be 1 in REQ and DRAIN and 0 in IDLE and HOLD. imem_addr shall equal pc in REQ and the outstanding address in DRAIN.
REQ-014 pc4 shall equal pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0. pc4 is computed by one 32-bit ripple adder instance with cin=0.
REQ-015 REQ with ack, no redirect, and (stall=0 or if_valid=0):
- load if_pc=pc, if_pc4=pc4, if_inst=imem_rdata, if_valid=1;
- set pc to pc4;
- stay in REQ.
- Latency: ack in cycle t gives if_valid in t+1.
REQ-016 REQ with ack, no redirect, stall=1 and if_valid=1:
- capture imem_rdata and pc into a one-entry skid buffer;
- go to HOLD.
REQ-017 HOLD with stall=0 and no redirect:
- move the skid buffer into IF/ID;
- set pc to pc4;
- go to REQ.
- While stall=1, remain in HOLD.
REQ-018 Redirect takes priority over every other event in every state:
- if_valid becomes 0 next cycle;
- the skid buffer is discarded;
- pc becomes redirect_pc.
REQ-019 Redirect in REQ without ack in the same cycle: go to DRAIN. Redirect in REQ with ack in the same cycle: discard the data and stay in REQ.
REQ-020 DRAIN: keep the stale request until ack, discard the returned data, then go to REQ at the new pc.
- A further redirect in DRAIN overwrites pc and stays in DRAIN (or goes to REQ if ack arrives the same cycle).
REQ-021 If stall=1 and if_valid=0, stall shall be ignored (a bubble may be overwritten).
REQ-022 redirect=1 and stall=1 in the same cycle: the flush wins and if_valid becomes 0.
REQ-023 imem_ack outside REQ/DRAIN shall be ignored.

Reset
REQ-024 On rst=1, immediately and asynchronously:
- state=IDLE, pc=RESET_PC, skid buffer empty;
- if_valid=0, if_pc=0, if_pc4=0, if_inst=32'h0000_0013 (NOP).
REQ-025 The first request (imem_addr=RESET_PC) shall occur on the second rising edge after rst deasserts.
REQ-026 Reset asserted mid-request shall abandon the outstanding fetch; an ack arriving in IDLE is ignored.

Structure
REQ-027 The shared package shall hold:
- the state encoding (2-bit);
- the NOP constant 32'h0000_0013;
- XLEN=32.
REQ-028 Sub-modules: instantiate the team's parameterised ripple adder (N=32) for pc4. All other logic stays inside if_fetch_unit.

Verification
REQ-029 Reset release, ack each cycle one cycle after req, no stall: addresses 0,4,8,C are fetched; if_valid rises the cycle after the first ack with if_pc=0, if_pc4=4.
REQ-030 Ack on pc=8 while stall=1 and if_valid=1: enter HOLD, imem_req=0, outputs hold pc=4. stall drops 3 cycles later: next cycle if_pc=8, imem_addr=C.
REQ-031 Redirect to 32'h0000_0103 while a request to 0x10 is outstanding with ack 3 cycles later:
- if_valid=0 next cycle;
- DRAIN keeps imem_addr=0x10 until ack;
- data is discarded;
- next imem_addr=0x100.
REQ-032 Redirect and ack in the same cycle with stall=1: if_valid=0, no HOLD, next imem_addr=target.
REQ-033 RESET_PC=32'hFFFF_FFFC: first if_pc4=0, second fetch at address 0.
REQ-034 rst pulse while in HOLD: all outputs return to reset values asynchronously; a late ack is ignored; fetch restarts at RESET_PC.
